// File: rtl/scs8hd_clkgate_ctrl.sv
// Clock-enable sequencer for a gated clkbuf branch: merges requester demand into a
// registered CLKEN, delays ACK by a wake-up settling time and holds the clock on while idle.
module scs8hd_clkgate_ctrl #(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8,
    parameter int CW       = 4
) (
    input  logic            CLK,
    input  logic            RESETB,
    input  logic [NREQ-1:0] REQ,
    input  logic            FORCE_ON,
    output logic [NREQ-1:0] ACK,
    output logic            CLKEN,
    output logic            BUSY,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [CW-1:0] WAKE_INIT = CW'(WAKE_CYC);
    localparam logic [CW-1:0] IDLE_INIT = CW'(IDLE_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Valid/ready style does not apply here: REQ is a level held until ACK is seen,
    // ACK is a level that follows REQ one edge later once the gated clock is stable.

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            clken_q, clken_d;
    logic            busy_q, busy_d;
    logic            demand;

    assign demand = (|REQ) | FORCE_ON;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        clken_d = clken_q;
        busy_d  = busy_q;

        case (state_q)
            ST_OFF: begin
                if (demand) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_INIT;
                    clken_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            ST_WAKE: begin
                if (cnt_q == CNT_ONE) begin
                    if (demand) begin
                        state_d = ST_ON;
                        ack_d   = REQ;
                    end else if (IDLE_CYC == 0) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                        clken_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = IDLE_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_ON: begin
                if (demand) begin
                    ack_d = REQ;
                end else if (IDLE_CYC == 0) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    clken_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = IDLE_INIT;
                end
            end

            ST_HOLD: begin
                // The clock never stopped, so returning demand skips the wake delay.
                if (demand) begin
                    state_d = ST_ON;
                    ack_d   = REQ;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    clken_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
                clken_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            ack_q   <= '0;
            clken_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            clken_q <= clken_d;
            busy_q  <= busy_d;
        end
    end

    assign ACK       = ack_q;
    assign CLKEN     = clken_q;
    assign BUSY      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_scs8hd_clkgate_ctrl.sv
// Directed vector table for scs8hd_clkgate_ctrl plus hand-written reset sequences.
module tb_scs8hd_clkgate_ctrl;

    localparam int NREQ = 4;

    logic            clk;
    logic            resetb;
    logic [NREQ-1:0] req;
    logic            force_on;
    logic [NREQ-1:0] ack;
    logic            clken;
    logic            busy;
    logic [1:0]      dbg_state;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [NREQ-1:0] req;
        logic            force_on;
        logic [NREQ-1:0] exp_ack;
        logic            exp_clken;
        logic            exp_busy;
    } vec_t;

    vec_t vecs[$];

    scs8hd_clkgate_ctrl #(
        .NREQ(NREQ), .WAKE_CYC(2), .IDLE_CYC(8), .CW(4)
    ) dut (
        .CLK      (clk),
        .RESETB   (resetb),
        .REQ      (req),
        .FORCE_ON (force_on),
        .ACK      (ack),
        .CLKEN    (clken),
        .BUSY     (busy),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [NREQ-1:0] r, input logic f, input logic [NREQ-1:0] a,
                       input logic c, input logic b, input int n);
        vec_t v;
        v.req = r; v.force_on = f; v.exp_ack = a; v.exp_clken = c; v.exp_busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic [NREQ-1:0] a, input logic c,
                              input logic b);
        check({tag, ".ack"},   32'(ack),   32'(a));
        check({tag, ".clken"}, 32'(clken), 32'(c));
        check({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Wake from reset release, then idle hold-off.
        add(4'b0001, 0, 4'b0000, 1, 1, 2);
        add(4'b0001, 0, 4'b0001, 1, 1, 2);
        add(4'b0000, 0, 4'b0000, 1, 1, 8);
        add(4'b0000, 0, 4'b0000, 0, 0, 2);
        // Re-request in HOLD after 3 edges.
        add(4'b0001, 0, 4'b0000, 1, 1, 2);
        add(4'b0001, 0, 4'b0001, 1, 1, 1);
        add(4'b0000, 0, 4'b0000, 1, 1, 3);
        add(4'b0100, 0, 4'b0100, 1, 1, 2);
        add(4'b0000, 0, 4'b0000, 1, 1, 8);
        add(4'b0000, 0, 4'b0000, 0, 0, 1);
        // One-cycle pulse: full wake, then full hold-off.
        add(4'b0010, 0, 4'b0000, 1, 1, 1);
        add(4'b0000, 0, 4'b0000, 1, 1, 9);
        add(4'b0000, 0, 4'b0000, 0, 0, 1);
        // FORCE_ON without requesters, then a requester joins.
        add(4'b0000, 1, 4'b0000, 1, 1, 5);
        add(4'b1000, 1, 4'b1000, 1, 1, 1);
        add(4'b1010, 1, 4'b1010, 1, 1, 1);
        add(4'b0000, 1, 4'b0000, 1, 1, 2);
        add(4'b0000, 0, 4'b0000, 1, 1, 2);
        add(4'b0001, 0, 4'b0001, 1, 1, 1);

        req      = 4'b1111;
        force_on = 1'b0;
        resetb   = 1'b0;
        #1;
        check_outs("reset", 4'b0000, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_outs("reset_hold", 4'b0000, 0, 0);

        req    = 4'b0001;
        resetb = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            req      = vecs[i].req;
            force_on = vecs[i].force_on;
            @(posedge clk);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_clken,
                       vecs[i].exp_busy);
        end

        // Asynchronous reset between edges while ON with ACK high.
        check_outs("pre_async", 4'b0001, 1, 1);
        #2 resetb = 1'b0;
        #1;
        check_outs("async_rst", 4'b0000, 0, 0);
        check("async_rst.state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        req    = 4'b0000;
        resetb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outs("post_rst", 4'b0000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scs8hd_clkgate_ctrl.md
# scs8hd_clkgate_ctrl

Clock-enable sequencer for a gated clock-buffer branch in the scs8hd library. It merges demand from NREQ requesters into one registered enable (CLKEN) that drives a latch-based integrated clock gate in front of a clkbuf tree. It waits a programmable wake-up settling time before acknowledging requesters. It holds the clock on for an idle hold-off before gating, so bursty requesters do not toggle the gate every cycle.

## Interface
- NREQ, 4, number of requesters (1..16)
- WAKE_CYC, 2, cycles from CLKEN rise to first ACK (>=1)
- IDLE_CYC, 8, cycles CLKEN stays high after demand drops (>=0)
- CW, 4, counter width; 2**CW > max(WAKE_CYC, IDLE_CYC)

- CLK  input  1  free-running (ungated) clock; all state updates on rising edge
- RESETB  input  1  asynchronous, active-low reset
- REQ  input  NREQ  per-requester clock demand, level, synchronous to CLK
- FORCE_ON  input  1  test/debug demand; keeps clock on, never acknowledged
- ACK  output  NREQ  registered; ACK[i]=1 means gated clock is stable for requester i
- CLKEN  output  1  registered enable to clock gate
- BUSY  output  1  registered; 1 whenever state != OFF

## Operation
- Demand D = |REQ | FORCE_ON, sampled each rising edge.
- States: OFF, WAKE, ON, HOLD. Down-counter cnt[CW-1:0].
- OFF: CLKEN=0, ACK=0, BUSY=0. D=1 -> WAKE, cnt<=WAKE_CYC.
- WAKE: CLKEN=1, ACK=0. cnt decrements each cycle. When cnt==1: if D=1 -> ON with ACK<=REQ; if D=0 -> HOLD with cnt<=IDLE_CYC (or OFF if IDLE_CYC=0). WAKE is never aborted early.
- ON: CLKEN=1, ACK<=REQ every cycle. D=0 -> HOLD, cnt<=IDLE_CYC, ACK<=0. If IDLE_CYC=0, D=0 -> OFF directly.
- HOLD: CLKEN=1, ACK=0. D=1 -> ON with ACK<=REQ, no wake delay. D=0: cnt decrements; cnt==1 with D=0 -> OFF.
- FORCE_ON=1 with REQ=0: goes ON and stays ON, ACK=0.
- Simultaneous requester changes in ON: each ACK bit follows its own REQ with one cycle of latency. A newly raised REQ[i] while ON receives ACK next cycle, with no wake penalty.
- Requester protocol: hold REQ[i] until ACK[i] is seen. Deasserting REQ early is legal; the controller drops ACK accordingly.

## Timing
- Reset (RESETB=0): immediately and asynchronously, state=OFF, cnt=0, CLKEN=0, ACK=0, BUSY=0. Reset mid-operation gates the clock at once; the downstream ICG latch absorbs the glitch risk.
- All outputs are flop outputs; no combinational path from REQ/FORCE_ON to any output.
- Latency from OFF: REQ high in the cycle before edge t -> CLKEN=1 and BUSY=1 after edge t -> ACK=1 after edge t+WAKE_CYC.
- Release: last REQ low before edge t in ON -> ACK=0 after t. CLKEN=0 after edge t+IDLE_CYC (IDLE_CYC>=1), or after t itself (IDLE_CYC=0).
- CLKEN changes only at CLK rising edges, one change per edge at most.

## Test plan
- Reset: RESETB=0 with REQ=4'b1111 -> CLKEN=0, ACK=0, BUSY=0. Release reset with REQ=4'b0001 -> CLKEN=1 after the first edge, ACK=4'b0001 two edges later (WAKE_CYC=2).
- Idle hold-off: in ON with REQ=4'b0001, drop REQ -> ACK=0 next edge. CLKEN stays 1 for exactly 8 edges, then 0; BUSY falls with CLKEN.
- Re-request in HOLD: drop REQ, re-raise REQ=4'b0100 after 3 edges -> ACK=4'b0100 on the next edge, with no wake delay; CLKEN never falls.
- Demand lost in WAKE: pulse REQ=4'b0010 for one cycle from OFF -> WAKE runs 2 cycles with ACK=0, then HOLD for 8 cycles, then OFF.
- FORCE_ON: FORCE_ON=1, REQ=0 -> CLKEN=1 indefinitely, ACK=0. Add REQ=4'b1000 -> ACK=4'b1000 one edge later.
- Mid-operation reset: assert RESETB=0 asynchronously between edges while ON -> CLKEN and ACK fall without waiting for a CLK edge.
